data_bus_arbiter: RTL and testbench

Two-master arbiter and access sequencer for the shared data-memory/peripheral bus behind the pipelined CPU. Master 0 is the CPU MEM stage and master 1 is the boot loader/DMA engine. The block serialises their word accesses onto one synchronous single-port slave with a configurable read latency. It generates the CPU stall that freezes the pipeline while a MEM-stage access is outstanding.

---
 rtl/data_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_data_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master word-access arbiter and slave sequencer (tie policy: ARB_ROUND_ROBIN_EN)
module data_bus_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_gnt,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_gnt,
  output logic          cpu_stall,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       owner;     // 0 = master 0 (CPU), 1 = master 1 (DMA)
  logic       last_gnt;  // master granted on the most recent IDLE->ACCESS
  logic       any_req;
  logic       pick;

  assign any_req = m0_req | m1_req;

  // Winner of the current request set; a lone requester always wins
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick = ~last_gnt;
`else
      // fixed priority: CPU wins, last_gnt is tracked but masked off here
      pick = last_gnt & 1'b0;
`endif
    end else if (m1_req) begin
      pick = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state sequencing: one ACCESS strobe, WAIT_CYCLES+1 wait cycles, one ack cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = WAIT;
      WAIT:    if (cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latching, latency counter and read-data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 4'd0;
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= pick;
            last_gnt  <= pick;
            mem_we    <= pick ? m1_we    : m0_we;
            mem_addr  <= pick ? m1_addr  : m0_addr;
            mem_wdata <= pick ? m1_wdata : m0_wdata;
          end
        end
        ACCESS: begin
          cnt <= WAIT_INIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            // writes run the same cycle count but leave rdata alone
            if (!mem_we) begin
              if (owner) begin
                m1_rdata <= mem_rdata;
              end else begin
                m0_rdata <= mem_rdata;
              end
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign mem_en    = (state == ACCESS);
  assign m0_gnt    = busy & ~owner;
  assign m1_gnt    = busy & owner;
  assign m0_ack    = (state == DONE) & ~owner;
  assign m1_ack    = (state == DONE) & owner;
  assign cpu_stall = m0_req & ~m0_ack;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - directed bench for data_bus_arbiter at WAIT_CYCLES 0 and 3
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr [2];
  logic [31:0] m0_wdata [2];
  logic [31:0] m1_addr [2];
  logic [31:0] m1_wdata [2];
  logic [31:0] m0_rdata [2];
  logic [31:0] m1_rdata [2];
  logic [1:0]  m0_ack, m1_ack, m0_gnt, m1_gnt, cpu_stall, busy, mem_en, mem_we;
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cur_w    = 0;

  always #5 clk = ~clk;

  // Two DUTs (W=0 and W=3), each with a small word-addressed slave model
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] smem [16];
    logic [31:0] hold = 32'h0;
    int          k = 100;
    bit          loaded;

    data_bus_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(g * 3)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
      .m0_rdata(m0_rdata[g]), .m0_ack(m0_ack[g]), .m0_gnt(m0_gnt[g]),
      .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
      .m1_rdata(m1_rdata[g]), .m1_ack(m1_ack[g]), .m1_gnt(m1_gnt[g]),
      .cpu_stall(cpu_stall[g]), .busy(busy[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );

    // Slave: writes commit on the strobe edge; read data is valid only W+1 cycles after it
    always @(posedge clk) begin
      if (!loaded) begin
        for (int j = 0; j < 16; j++) smem[j] <= 32'hA500_0000 | 32'(j);
        smem[4] <= 32'hDEADBEEF;
        loaded  <= 1'b1;
      end else if (mem_en[g] && mem_we[g]) begin
        smem[mem_addr[g][5:2]] <= mem_wdata[g];
      end
      if (mem_en[g]) begin
        k    <= 0;
        hold <= smem[mem_addr[g][5:2]];
      end else if (k < 100) begin
        k <= k + 1;
      end
    end

    assign mem_rdata[g] = (k == g * 3) ? hold : 32'hBAD0BAD0;
  end

  function automatic int wc(input int i);
    return i * 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL W=%0d %s: got 0x%08h expected 0x%08h", cur_w, tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input int m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req[i] = req; m0_we[i] = we; m0_addr[i] = addr; m0_wdata[i] = wdata;
    end else begin
      m1_req[i] = req; m1_we[i] = we; m1_addr[i] = addr; m1_wdata[i] = wdata;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One transaction from master m; cycle 0 is the IDLE cycle in which req is first seen
  task automatic txn(input int i, input int m, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input bit drop);
    int ack_cyc = -1, en_cnt = 0, en_cyc = -1, stall_cnt = 0, gnt_cnt = 0;
    int other_gnt = 0, other_ack = 0, busy_cnt = 0;
    logic we_en = 1'b0, stall_ack = 1'b1;
    logic [31:0] addr_en = 32'h0, wdata_en = 32'h0, rd_ack = 32'h0;
    @(negedge clk);
    drive(i, m, 1'b1, we, addr, wdata);
    for (int c = 0; c < 40 && ack_cyc < 0; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (mem_en[i]) begin
        en_cnt++; en_cyc = c; we_en = mem_we[i]; addr_en = mem_addr[i]; wdata_en = mem_wdata[i];
      end
      if (cpu_stall[i]) stall_cnt++;
      if (busy[i]) busy_cnt++;
      if ((m == 0) ? m0_gnt[i] : m1_gnt[i]) gnt_cnt++;
      if ((m == 0) ? m1_gnt[i] : m0_gnt[i]) other_gnt++;
      if ((m == 0) ? m1_ack[i] : m0_ack[i]) other_ack++;
      if ((m == 0) ? m0_ack[i] : m1_ack[i]) begin
        ack_cyc   = c;
        stall_ack = cpu_stall[i];
        rd_ack    = (m == 0) ? m0_rdata[i] : m1_rdata[i];
        drive(i, m, 1'b0, we, addr, wdata);
      end else if (drop && c == 2) begin
        drive(i, m, 1'b0, we, addr, wdata);
      end
    end
    drive(i, m, 1'b0, we, addr, wdata);
    check("ack_cycle", 32'(ack_cyc), 32'(3 + wc(i)));
    check("mem_en_count", 32'(en_cnt), 32'd1);
    check("mem_en_cycle", 32'(en_cyc), 32'd1);
    check("mem_we", 32'(we_en), 32'(we));
    check("mem_addr", addr_en, addr);
    if (we) check("mem_wdata", wdata_en, wdata);
    check("gnt_cycles", 32'(gnt_cnt), 32'(3 + wc(i)));
    check("busy_cycles", 32'(busy_cnt), 32'(3 + wc(i)));
    check("other_gnt", 32'(other_gnt), 32'd0);
    check("other_ack", 32'(other_ack), 32'd0);
    check("rdata_at_ack", rd_ack, exp_rd);
    if (m == 0 && !drop) begin
      check("stall_cycles", 32'(stall_cnt), 32'(3 + wc(i)));
      check("stall_in_ack", 32'(stall_ack), 32'd0);
    end
  endtask

  task automatic idle_check(input int i, input string tag);
    int busy_cnt = 0, en_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (busy[i]) busy_cnt++;
      if (mem_en[i]) en_cnt++;
    end
    check({tag, "_busy"}, 32'(busy_cnt), 32'd0);
    check({tag, "_mem_en"}, 32'(en_cnt), 32'd0);
  endtask

  task automatic tie_test(input int i);
    int order [4] = '{9, 9, 9, 9};
    int exp_order [4];
    int n = 0;
    int drained = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    pulse_reset();
    @(negedge clk);
    drive(i, 0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    drive(i, 1, 1'b1, 1'b0, 32'h4000_0000, 32'h0);
    for (int c = 0; c < 4 * (4 + wc(i)) + 8 && n < 4; c++) begin
      #1;
      if (m0_ack[i]) begin
        order[n] = 0; n++;
      end else if (m1_ack[i]) begin
        order[n] = 1; n++;
      end
      @(negedge clk);
    end
    drive(i, 0, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
    drive(i, 1, 1'b0, 1'b0, 32'h4000_0000, 32'h0);
    check("tie_ack_count", 32'(n), 32'd4);
    for (int j = 0; j < 4; j++) check($sformatf("tie_order[%0d]", j), 32'(order[j]), 32'(exp_order[j]));
    for (int c = 0; c < 40 && !drained; c++) begin
      @(negedge clk);
      #1;
      if (!busy[i]) drained = 1;
    end
    check("tie_drain", 32'(drained), 32'd1);
  endtask

  task automatic reset_mid_test(input int i);
    int acks = 0;
    @(negedge clk);
    drive(i, 0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("pre_reset_in_wait", 32'(busy[i] && !mem_en[i] && m0_gnt[i]), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy[i]), 32'd0);
    check("rst_gnt", 32'({m0_gnt[i], m1_gnt[i]}), 32'd0);
    check("rst_mem_en", 32'(mem_en[i]), 32'd0);
    check("rst_m0_rdata", m0_rdata[i], 32'h0);
    check("rst_mem_addr", mem_addr[i], 32'h0);
    check("rst_stall_follows_req", 32'(cpu_stall[i]), 32'd1);
    drive(i, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 4 + wc(i); c++) begin
      @(negedge clk);
      #1;
      if (m0_ack[i] || m1_ack[i]) acks++;
    end
    check("rst_no_ack", 32'(acks), 32'd0);
    reset = 1'b1;
    txn(i, 0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_req = '0; m0_we = '0; m1_req = '0; m1_we = '0;
    for (int i = 0; i < 2; i++) begin
      m0_addr[i] = '0; m0_wdata[i] = '0; m1_addr[i] = '0; m1_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cur_w = wc(i);
      pulse_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_mem_en", 32'(mem_en[i]), 32'd0);
      check("rst_mem_we", 32'(mem_we[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_acks", 32'({m0_ack[i], m1_ack[i]}), 32'd0);
      check("rst_gnts", 32'({m0_gnt[i], m1_gnt[i]}), 32'd0);
      check("rst_mem_addr", mem_addr[i], 32'h0);
      check("rst_mem_wdata", mem_wdata[i], 32'h0);
      check("rst_m0_rdata", m0_rdata[i], 32'h0);
      check("rst_m1_rdata", m1_rdata[i], 32'h0);
      check("rst_stall_low", 32'(cpu_stall[i]), 32'd0);
      m0_req[i] = 1'b1;
      #1;
      check("rst_stall_high", 32'(cpu_stall[i]), 32'd1);
      m0_req[i] = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      txn(i, 0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 1'b0);
      txn(i, 1, 1'b1, 32'h4000_0000, 32'h1234_5678, 32'h0, 1'b0);
      idle_check(i, "after_write");
      check("idle_hold_addr", mem_addr[i], 32'h4000_0000);
      check("idle_hold_wdata", mem_wdata[i], 32'h1234_5678);
      check("idle_hold_we", 32'(mem_we[i]), 32'd1);
      txn(i, 1, 1'b0, 32'h4000_0000, 32'h0, 32'h1234_5678, 1'b0);
      txn(i, 0, 1'b0, 32'h0000_0020, 32'h0, 32'hA500_0008, 1'b1);
      idle_check(i, "after_drop");
      tie_test(i);
      reset_mid_test(i);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
